mcs_fpro_bridge: RTL and testbench



---
 rtl/mcs_fpro_bridge.sv | 125 ++++++++++++
 tb/tb_mcs_fpro_bridge.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mcs_fpro_bridge.sv
// MicroBlaze MCS I/O bus to FPro bus bridge: window decode, video/MMIO select, fixed-latency reads.
// Optional BRG_ERR_CHECK_EN: sticky brg_err and suppression of partial-word writes.
module mcs_fpro_bridge #(
    parameter logic [31:0] BRG_BASE = 32'hC000_0000,
    parameter int          RD_WAIT  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_addr_strobe,
    input  logic        io_read_strobe,
    input  logic        io_write_strobe,
    input  logic [3:0]  io_byte_enable,
    input  logic [31:0] io_address,
    input  logic [31:0] io_write_data,
    output logic [31:0] io_read_data,
    output logic        io_ready,
    output logic        fp_video_cs,
    output logic        fp_mmio_cs,
    output logic        fp_wr,
    output logic        fp_rd,
    output logic [21:0] fp_addr,
    output logic [31:0] fp_wr_data,
    input  logic [31:0] fp_rd_data,
    output logic        brg_err
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RWAIT, S_RESP} state_t;

    localparam logic [3:0] WAIT_N = 4'(RD_WAIT);

    state_t      r_state, w_next;
    logic [21:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [3:0]  r_cnt;
    logic        r_wr;
    logic        r_video;
    logic        w_accept, w_in_win, w_legal, w_go, w_issue, w_sup;
    logic        w_unused;

    assign w_accept = (r_state == S_IDLE) && io_addr_strobe;
    assign w_in_win = (io_address[31:24] == BRG_BASE[31:24]);
    assign w_legal  = io_read_strobe ^ io_write_strobe;
    assign w_go     = w_in_win && w_legal;
    assign w_issue  = (r_state == S_ISSUE);
    assign w_unused = &{1'b0, io_address[1:0], io_byte_enable};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (io_addr_strobe) w_next = w_go ? S_ISSUE : S_RESP;
            S_ISSUE: w_next = (!r_wr && RD_WAIT != 0) ? S_RWAIT : S_RESP;
            S_RWAIT: if (r_cnt == WAIT_N) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_video <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr    <= io_write_strobe;
                r_addr  <= io_address[23:2];
                r_video <= io_address[23];
                r_wdata <= io_write_data;
                if (!w_go) r_rdata <= '0;
            end
            // Read data is captured on the last cycle before RESP.
            if (w_issue && !r_wr) begin
                if (RD_WAIT == 0) r_rdata <= fp_rd_data;
                else              r_cnt   <= 4'd1;
            end
            if (r_state == S_RWAIT) begin
                if (r_cnt == WAIT_N) begin
                    r_rdata <= fp_rd_data;
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= r_cnt + 4'd1;
                end
            end
        end
    end

`ifdef BRG_ERR_CHECK_EN
    logic r_sup;
    logic r_err;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sup <= 1'b0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_sup <= io_write_strobe && !io_read_strobe && (io_byte_enable != 4'hF);
            if (!w_in_win || (io_read_strobe && io_write_strobe) ||
                (io_write_strobe && io_byte_enable != 4'hF))
                r_err <= 1'b1;
        end
    end
    assign w_sup   = r_sup;
    assign brg_err = r_err;
`else
    assign w_sup   = 1'b0;
    assign brg_err = 1'b0;
`endif

    // A suppressed partial write issues no FPro cycle at all.
    assign fp_video_cs  = w_issue && !w_sup && r_video;
    assign fp_mmio_cs   = w_issue && !w_sup && !r_video;
    assign fp_rd        = w_issue && !r_wr;
    assign fp_wr        = w_issue && r_wr && !w_sup;
    assign fp_addr      = r_addr;
    assign fp_wr_data   = r_wdata;
    assign io_ready     = (r_state == S_RESP);
    assign io_read_data = r_rdata;
endmodule

// File: tb/tb_mcs_fpro_bridge.sv
// Directed bench for mcs_fpro_bridge: one instance with RD_WAIT=0, one with RD_WAIT=3.
module tb_mcs_fpro_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic        as0, as3, rds, wrs;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdin;

    logic [31:0] rdata0, wdat0, rdata3, wdat3;
    logic [21:0] addr0, addr3;
    logic        rdy0, vcs0, mcs0, wr0, rd0, err0;
    logic        rdy3, vcs3, mcs3, wr3, rd3, err3;

    int n_chk = 0;
    int n_err = 0;
    int seen;

    always #5 clk = ~clk;

    mcs_fpro_bridge #(.BRG_BASE(32'hC000_0000), .RD_WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .io_addr_strobe(as0), .io_read_strobe(rds),
        .io_write_strobe(wrs), .io_byte_enable(be), .io_address(addr),
        .io_write_data(wdata), .io_read_data(rdata0), .io_ready(rdy0),
        .fp_video_cs(vcs0), .fp_mmio_cs(mcs0), .fp_wr(wr0), .fp_rd(rd0),
        .fp_addr(addr0), .fp_wr_data(wdat0), .fp_rd_data(rdin), .brg_err(err0));

    mcs_fpro_bridge #(.BRG_BASE(32'hC000_0000), .RD_WAIT(3)) dut3 (
        .clk(clk), .reset(reset), .io_addr_strobe(as3), .io_read_strobe(rds),
        .io_write_strobe(wrs), .io_byte_enable(be), .io_address(addr),
        .io_write_data(wdata), .io_read_data(rdata3), .io_ready(rdy3),
        .fp_video_cs(vcs3), .fp_mmio_cs(mcs3), .fp_wr(wr3), .fp_rd(rd3),
        .fp_addr(addr3), .fp_wr_data(wdat3), .fp_rd_data(rdin), .brg_err(err3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic req(input bit sel3, input bit r, input bit w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
        rds = r; wrs = w; be = b; addr = a; wdata = d;
        if (sel3) as3 = 1'b1; else as0 = 1'b1;
        tick();
        as0 = 1'b0; as3 = 1'b0; rds = 1'b0; wrs = 1'b0;
    endtask

    initial begin
        reset = 1'b1; as0 = 0; as3 = 0; rds = 0; wrs = 0; be = 4'h0;
        addr = '0; wdata = '0; rdin = '0;
        tick(); tick();
        chk("rst_outs0", {rdy0, vcs0, mcs0, wr0, rd0, err0}, 32'h0);
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_addr0", {10'h0, addr0}, 32'h0);
        reset = 1'b0;
        tick();

        // 1: full-word write to MMIO
        req(0, 0, 1, 4'hF, 32'hC000_0104, 32'h1234_5678);
        chk("t1_cs", {vcs0, mcs0, wr0, rd0, rdy0}, 32'b01100);
        chk("t1_addr", {10'h0, addr0}, 32'h41);
        chk("t1_wdata", wdat0, 32'h1234_5678);
        tick();
        chk("t1_ready", {rdy0, wr0, mcs0}, 32'b100);
        tick();
        chk("t1_ready_pulse", rdy0, 32'h0);
        chk("t1_addr_held", {10'h0, addr0}, 32'h41);

        // 2: video read, no wait
        rdin = 32'hCAFE_F00D;
        req(0, 1, 0, 4'hF, 32'hC080_0010, 32'h0);
        chk("t2_cs", {vcs0, mcs0, wr0, rd0, rdy0}, 32'b10010);
        chk("t2_addr", {10'h0, addr0}, 32'h20_0004);
        tick();
        chk("t2_ready", {rdy0, rd0}, 32'b10);
        chk("t2_rdata", rdata0, 32'hCAFE_F00D);

        // 3: read with RD_WAIT=3 captures the T+4 value
        tick();
        rdin = 32'h0;
        req(1, 1, 0, 4'hF, 32'hC000_0020, 32'h0);
        rdin = 32'h1111_1111;
        chk("t3_rd", {mcs3, rd3, rdy3}, 32'b110);
        tick(); rdin = 32'h2222_2222;
        chk("t3_t2", {rd3, rdy3}, 32'b00);
        tick(); rdin = 32'h3333_3333;
        tick(); rdin = 32'h4444_4444;
        chk("t3_t4", rdy3, 32'h0);
        tick(); rdin = 32'h5555_5555;
        chk("t3_ready", rdy3, 32'h1);
        chk("t3_rdata", rdata3, 32'h4444_4444);
        tick();
        chk("t3_hold", {31'h0, rdy3}, 32'h0);
        chk("t3_rdata_hold", rdata3, 32'h4444_4444);

        // 4: out-of-window read
        req(0, 1, 0, 4'hF, 32'h8000_0000, 32'h0);
        chk("t4_ready", {rdy0, vcs0, mcs0, wr0, rd0}, 32'b10000);
        chk("t4_rdata", rdata0, 32'h0);
`ifdef BRG_ERR_CHECK_EN
        chk("t4_err", err0, 32'h1);
`else
        chk("t4_err", err0, 32'h0);
`endif
        tick();
        chk("t4_ready_pulse", rdy0, 32'h0);

        // 5: partial write
        req(0, 0, 1, 4'h3, 32'hC000_0008, 32'hDEAD_BEEF);
`ifdef BRG_ERR_CHECK_EN
        chk("t5_wr", {mcs0, wr0}, 32'b00);
`else
        chk("t5_wr", {mcs0, wr0}, 32'b11);
        chk("t5_wdata", wdat0, 32'hDEAD_BEEF);
`endif
        chk("t5_addr", {10'h0, addr0}, 32'h2);
        tick();
        chk("t5_ready", rdy0, 32'h1);
`ifdef BRG_ERR_CHECK_EN
        chk("t5_err", err0, 32'h1);
`else
        chk("t5_err", err0, 32'h0);
`endif
        tick();

        // 6: reset during a waited read aborts it
        rdin = 32'h7777_7777;
        req(1, 1, 0, 4'hF, 32'hC000_0030, 32'h0);
        chk("t6_rd", rd3, 32'h1);
        reset = 1'b1;
        #1;
        chk("t6_rst_outs", {rdy3, vcs3, mcs3, wr3, rd3, err3}, 32'h0);
        chk("t6_rst_rdata", rdata3, 32'h0);
        tick();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rdy3) seen++;
        end
        chk("t6_no_ready", seen, 32'h0);
        req(1, 0, 1, 4'hF, 32'hC000_0040, 32'hA5A5_0F0F);
        chk("t6_wr", {mcs3, wr3}, 32'b11);
        chk("t6_wdata", wdat3, 32'hA5A5_0F0F);
        tick();
        chk("t6_ready", rdy3, 32'h1);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
